// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: two requesters share one 16x16 multiplier through an IDLE/MUL/RESP FSM.
// Optional feature: define MUL_ARB_RR_EN for round-robin arbitration (default is fixed priority, requester 0 wins).

// mul16: exact combinational 16x16 unsigned multiplier
module mul16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = 32'(a) * 32'(b);
endmodule

module mul_share_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [31:0]      rsp0_p,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    output logic [31:0]      rsp1_p,
    input  logic             rsp1_ready,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t           state_q, state_d;
    logic [15:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [31:0]      res_q, res_d, prod;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             idle, gnt0, gnt1, grant;

    mul16 u_mul (.a(op_a_q), .b(op_b_q), .p(prod));

    assign idle = (state_q == IDLE);

`ifdef MUL_ARB_RR_EN
    logic ptr_q, ptr_d;

    // requester 1 wins when alone or when the pointer gives it priority
    always_comb begin
        gnt1  = req1_valid & (~req0_valid | ptr_q);
        gnt0  = req0_valid & ~gnt1;
        ptr_d = (idle & (gnt0 | gnt1)) ? ~gnt1 : ptr_q;
    end

    // round-robin pointer, requester 0 first after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
`else
    // fixed priority: requester 0 always wins
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
    end
`endif

    assign grant = idle & (gnt0 | gnt1);

    // readies are gated by rst_n so they read 0 while reset is held
    assign req0_ready = rst_n & idle & gnt0;
    assign req1_ready = rst_n & idle & gnt1;
    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) & owner_q;
    assign rsp0_p     = res_q;
    assign rsp1_p     = res_q;
    assign busy       = ~idle;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

    // next-state: capture operands on grant, product in MUL, wait for owner's rsp_ready in RESP
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        owner_d = owner_q;
        cnt0_d  = (idle & gnt0 & ~&cnt0_q) ? cnt0_q + 1'b1 : cnt0_q;
        cnt1_d  = (idle & gnt1 & ~&cnt1_q) ? cnt1_q + 1'b1 : cnt1_q;
        if (grant) begin
            state_d = MUL;
            op_a_d  = gnt1 ? req1_a : req0_a;
            op_b_d  = gnt1 ? req1_b : req0_b;
            owner_d = gnt1;
        end else if (state_q == MUL) begin
            state_d = RESP;
            res_d   = prod;
        end else if (state_q == RESP && (owner_q ? rsp1_ready : rsp0_ready)) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            owner_q <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            owner_q <= owner_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: transaction-level model checks of the shared multiplier arbiter
module tb_mul_share_arbiter;
`ifdef MUL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [31:0] rsp0_p, rsp1_p;
    logic [15:0] grant_cnt0, grant_cnt1;
    logic s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_busy;
    logic [31:0] s_rsp0_p, s_rsp1_p;
    logic [1:0] s_grant_cnt0, s_grant_cnt1;

    always #5 clk = ~clk;

    mul_share_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_p(rsp0_p), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_p(rsp1_p), .rsp1_ready(rsp1_ready),
        .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    mul_share_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_req1_ready),
        .rsp0_valid(s_rsp0_valid), .rsp0_p(s_rsp0_p), .rsp0_ready(rsp0_ready),
        .rsp1_valid(s_rsp1_valid), .rsp1_p(s_rsp1_p), .rsp1_ready(rsp1_ready),
        .busy(s_busy), .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
    );

    int checks = 0, errors = 0;
    // transaction model: one job in flight, age counts edges since its grant
    bit pend = 0, own = 0, rr = 0, acc0 = 0, acc1 = 0;
    int age = 0, cnt0 = 0, cnt1 = 0;
    logic [31:0] prod = 0;
    int gq[$];

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endfunction

    function automatic int pick();
        if (pend) return -1;
        if (req0_valid && req1_valid) return (RR && rr) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic int sat(int c, int m);
        return c < m ? c : m;
    endfunction

    task automatic compare();
        int  g = pick();
        bit  v = pend && age >= 2;
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(v && !own));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(v && own));
        if (v) begin
            chk("rsp0_p", rsp0_p, prod);
            chk("rsp1_p", rsp1_p, prod);
        end
        chk("busy", 32'(busy), 32'(pend));
        chk("grant_cnt0", 32'(grant_cnt0), 32'(cnt0));
        chk("grant_cnt1", 32'(grant_cnt1), 32'(cnt1));
        chk("s_grant_cnt0", 32'(s_grant_cnt0), 32'(sat(cnt0, 3)));
        chk("s_grant_cnt1", 32'(s_grant_cnt1), 32'(sat(cnt1, 3)));
        chk("s_rsp0_valid", 32'(s_rsp0_valid), 32'(v && !own));
    endtask

    task automatic tick();
        int g;
        @(posedge clk);
        g = pick();
        acc0 = 0;
        acc1 = 0;
        if (pend) begin
            if (age >= 2 && (own ? rsp1_ready : rsp0_ready)) pend = 0;
            else age++;
        end else if (g >= 0) begin
            pend = 1;
            own  = (g == 1);
            age  = 1;
            prod = g ? 32'(req1_a) * 32'(req1_b) : 32'(req0_a) * 32'(req0_b);
            rr   = (g == 0);
            if (g == 0) begin cnt0 = sat(cnt0 + 1, 65535); acc0 = 1; end
            else begin cnt1 = sat(cnt1 + 1, 65535); acc1 = 1; end
            gq.push_back(g);
        end
    endtask

    task automatic drive(input bit v0, input logic [15:0] a0, b0, input bit v1,
                         input logic [15:0] a1, b1, input bit r0, r1);
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1 compare();
    endtask

    task automatic cyc(input bit v0, input logic [15:0] a0, b0, input bit v1,
                       input logic [15:0] a1, b1, input bit r0, r1);
        drive(v0, a0, b0, v1, a1, b1, r0, r1);
        tick();
    endtask

    task automatic model_reset();
        pend = 0; rr = 0; cnt0 = 0; cnt1 = 0; age = 0;
    endtask

    task automatic chk_zero(string n);
        chk({n, "_req0_ready"}, 32'(req0_ready), 0);
        chk({n, "_req1_ready"}, 32'(req1_ready), 0);
        chk({n, "_rsp0_valid"}, 32'(rsp0_valid), 0);
        chk({n, "_rsp1_valid"}, 32'(rsp1_valid), 0);
        chk({n, "_rsp0_p"}, rsp0_p, 0);
        chk({n, "_busy"}, 32'(busy), 0);
        chk({n, "_cnt0"}, 32'(grant_cnt0), 0);
        chk({n, "_cnt1"}, 32'(grant_cnt1), 0);
    endtask

    function automatic logic [15:0] rnd16();
        int k = $urandom % 8;
        return k == 0 ? 16'h0 : k == 1 ? 16'hFFFF : 16'($urandom);
    endfunction

    initial begin
        bit cv0 = 0, cv1 = 0;
        logic [15:0] ca0 = 0, cb0 = 0, ca1 = 0, cb1 = 0;
        // reset held with requests present: everything reads 0
        req0_valid = 1; req1_valid = 1;
        #12 chk_zero("reset");
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;
        model_reset();
        // single request 0x1234 x 0x5678
        drive(1, 16'h1234, 16'h5678, 0, 0, 0, 1, 1);
        chk("single_ready", 32'(req0_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("single_mul_valid", 32'(rsp0_valid), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("single_valid", 32'(rsp0_valid), 1);
        chk("single_p", rsp0_p, 32'h06260060);
        chk("single_rsp1", 32'(rsp1_valid), 0);
        tick();
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 1);
        // reset pulse while in MUL
        cyc(1, 16'd100, 16'd200, 0, 0, 0, 1, 1);
        @(negedge clk);
        req0_valid = 1;
        #2 rst_n = 0;
        #1 chk_zero("mid_reset");
        model_reset();
        @(negedge clk);
        req0_valid = 0;
        rst_n = 1;
        #1 compare();
        tick();
        repeat (4) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1);
            chk("post_reset_rsp0", 32'(rsp0_valid), 0);
            tick();
        end
        // both requesting continuously
        gq.delete();
        for (int i = 0; i < 12; i++) begin
            drive(1, 16'd3, 16'd5, 1, 16'd7, 16'd9, 1, 1);
            if (pend && age >= 2) chk("both_p", rsp0_p, own ? 32'd63 : 32'd15);
            tick();
        end
        chk("both_grants", 32'(gq.size()), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk("grant_order", 32'(gq[i]), RR ? 32'(i % 2) : 0);
        chk("both_cnt1", 32'(grant_cnt1), RR ? 32'd2 : 32'd0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 1);
        // backpressure on requester 0 with 0xFFFF x 0xFFFF
        cyc(1, 16'hFFFF, 16'hFFFF, 1, 16'd2, 16'd3, 0, 1);
        cyc(0, 0, 0, 1, 16'd2, 16'd3, 0, 1);
        repeat (10) begin
            drive(0, 0, 0, 1, 16'd2, 16'd3, 0, 1);
            chk("bp_valid", 32'(rsp0_valid), 1);
            chk("bp_p", rsp0_p, 32'hFFFE0001);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_no_grant", 32'(req1_ready), 0);
            tick();
        end
        cyc(0, 0, 0, 1, 16'd2, 16'd3, 1, 1);
        cyc(0, 0, 0, 1, 16'd2, 16'd3, 1, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 1);
        // zero operand
        cyc(1, 16'h0, 16'hABCD, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk("zero_valid", 32'(rsp0_valid), 1);
        chk("zero_p", rsp0_p, 0);
        tick();
        // five more grants to requester 0: narrow counter pins at 3
        repeat (5) begin
            cyc(1, 16'd1, 16'd1, 0, 0, 0, 1, 1);
            repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 1);
        end
        chk("sat_cnt0", 32'(s_grant_cnt0), 3);
        // randomized traffic, requesters hold until accepted
        repeat (3000) begin
            if (acc0 || !cv0) begin cv0 = ($urandom % 3) != 0; ca0 = rnd16(); cb0 = rnd16(); end
            if (acc1 || !cv1) begin cv1 = ($urandom % 3) != 0; ca1 = rnd16(); cb1 = rnd16(); end
            cyc(cv0, ca0, cb0, cv1, ca1, cb1, ($urandom % 4) != 0, ($urandom % 4) != 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
